battle_controller: RTL and testbench
====================================

BATTLE_CONTROLLER -- requirements
Module: battle_controller

Interface
REQ-001 Parameter PLAYER_HP_INIT, default 100, player HP loaded on battle start.
REQ-002 Parameter ENEMY_HP_INIT, default 100, enemy HP loaded on battle start.
REQ-003 Parameter PP_INIT, default 10, PP loaded into each of the four weapon counters on battle start.
REQ-004 Parameter DMG0 / DMG1 / STRUGGLE_DMG, defaults 12 / 25 / 5, damage for weapon 0, weapon 1, and the no-PP move.
REQ-005 Parameter ENEMY_WAIT_FRAMES, default 60, frame ticks between the player's hit and the enemy's hit.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 start  in  1  one-cycle pulse; starts or restarts a battle.
REQ-010 move_valid  in  1  player move request.
REQ-011 move_sel  in  1  weapon select, 0 or 1.
REQ-012 move_ready  out  1  high only in PLAYER_TURN.
REQ-013 move_err  out  1  one-cycle pulse when a move is rejected.
REQ-014 hp_bus  out  16  {player_hp[7:0], enemy_hp[7:0]}; feeds the battle screen HP input.
REQ-015 p_pp0, p_pp1, e_pp0, e_pp1  out  8 each  PP counters.
REQ-016 state  out  3  current FSM state encoding.
REQ-017 win, lose  out  1 each  high while in WIN or LOSE respectively.

Function
REQ-018 FSM states: IDLE, PLAYER_TURN, PLAYER_HIT, ENEMY_WAIT, ENEMY_HIT, WIN, LOSE.
REQ-019 start in any state: load HP and PP initial values and enter PLAYER_TURN next cycle; start has priority over every other event.
REQ-020 PLAYER_TURN, move_valid=1, selected PP>0: latch move_sel and enter PLAYER_HIT.
REQ-021 PLAYER_TURN, move_valid=1, selected PP=0, other PP>0: pulse move_err for one cycle and stay in PLAYER_TURN.
REQ-022 PLAYER_TURN, both player PP=0: any move is accepted as a struggle with STRUGGLE_DMG and no PP change.
REQ-023 PLAYER_HIT, one cycle: enemy_hp <= max(enemy_hp - dmg, 0) and selected PP -= 1 (unless struggle).
REQ-024 PLAYER_HIT next state: WIN if the new enemy_hp = 0, else ENEMY_WAIT with the frame counter cleared.
REQ-025 ENEMY_WAIT: count frame_tick pulses; on the ENEMY_WAIT_FRAMES-th pulse enter ENEMY_HIT.
REQ-026 ENEMY_HIT weapon choice: weapon lfsr[0] if its e_pp>0, else the other weapon if its e_pp>0, else struggle.
REQ-027 ENEMY_HIT, one cycle: player_hp saturating-subtract the damage, and PP -= 1 for a weapon move.
REQ-028 ENEMY_HIT next state: LOSE if the new player_hp = 0, else PLAYER_TURN.
REQ-029 move_valid outside PLAYER_TURN is ignored, with no move_err.
REQ-030 All arithmetic is unsigned 8-bit; HP and PP never wrap below 0.
REQ-031 WIN and LOSE hold all values until start.
REQ-032 LFSR: 16-bit, x^16+x^14+x^13+x^11+1, seed 16'hACE1, steps every clk cycle, never all-zero.
REQ-033 All outputs are registered; HP and PP changes are visible the cycle after PLAYER_HIT or ENEMY_HIT.

Reset
REQ-034 rst: state=IDLE, hp_bus=0, all PP=0, move_ready=0, move_err=0, win=0, lose=0, frame counter=0, LFSR=seed.
REQ-035 rst deasserted mid-battle: the block restarts from IDLE and needs start to play.

Structure
REQ-036 Package battle_pkg holds the state enum, the state encodings, and the default damage, HP and PP constants.
REQ-037 Sub-module lfsr16 holds the LFSR (clk, rst, q[15:0]).

Verification
REQ-038 Reset, then start -> next cycle state=PLAYER_TURN, hp_bus=16'h6464, all PP=10, move_ready=1.
REQ-039 move_sel=1 accepted -> after PLAYER_HIT, enemy_hp=75 and p_pp1=9; after 60 frame_ticks, ENEMY_HIT, then player_hp=88 or 75.
REQ-040 p_pp0=0, p_pp1=3, move_sel=0 -> move_err one cycle, state stays PLAYER_TURN, no HP change.
REQ-041 enemy_hp=10, weapon 0 hit -> enemy_hp=0 (saturated), win=1; later move_valid ignored; start -> reload to 100/100.
REQ-042 Both player PP=0 -> move deals 5 damage and PP stays 0; player_hp=4 with enemy struggle -> player_hp=0, lose=1.
REQ-043 start asserted in ENEMY_WAIT at the same cycle as frame_tick -> PLAYER_TURN with initial values, frame counter cleared.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and constants for the turn-based battle controller.
// Holds the FSM state encoding, default HP/PP/damage values and the LFSR seed.
package battle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PLAYER_TURN = 3'd1,
        ST_PLAYER_HIT  = 3'd2,
        ST_ENEMY_WAIT  = 3'd3,
        ST_ENEMY_HIT   = 3'd4,
        ST_WIN         = 3'd5,
        ST_LOSE        = 3'd6
    } state_t;

    localparam int DEF_PLAYER_HP   = 100;
    localparam int DEF_ENEMY_HP    = 100;
    localparam int DEF_PP          = 10;
    localparam int DEF_DMG0        = 12;
    localparam int DEF_DMG1        = 25;
    localparam int DEF_STRUGGLE    = 5;
    localparam int DEF_WAIT_FRAMES = 60;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // HP and PP floor at zero instead of wrapping.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) stepping every clock.
// Used as the enemy's weapon-choice coin.
module lfsr16
    import battle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic        fb;

    always_comb begin
        fb  = q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5];
        q_d = {fb, q_q[15:1]};
        // The all-zero state is a lock-up; fall back to the seed if ever reached.
        if (q_d == 16'h0000) begin
            q_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/battle_controller.sv
// Turn-based battle FSM: player move, delayed enemy counter-attack, HP/PP bookkeeping.
// All outputs come straight from flops; HP/PP updates land the cycle after each HIT state.
module battle_controller
    import battle_pkg::*;
#(
    parameter int PLAYER_HP_INIT    = DEF_PLAYER_HP,
    parameter int ENEMY_HP_INIT     = DEF_ENEMY_HP,
    parameter int PP_INIT           = DEF_PP,
    parameter int DMG0              = DEF_DMG0,
    parameter int DMG1              = DEF_DMG1,
    parameter int STRUGGLE_DMG      = DEF_STRUGGLE,
    parameter int ENEMY_WAIT_FRAMES = DEF_WAIT_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        move_valid,
    input  logic        move_sel,
    output logic        move_ready,
    output logic        move_err,
    output logic [15:0] hp_bus,
    output logic [7:0]  p_pp0,
    output logic [7:0]  p_pp1,
    output logic [7:0]  e_pp0,
    output logic [7:0]  e_pp1,
    output logic [2:0]  state,
    output logic        win,
    output logic        lose
);

    localparam logic [7:0]  P_HP_B     = 8'(PLAYER_HP_INIT);
    localparam logic [7:0]  E_HP_B     = 8'(ENEMY_HP_INIT);
    localparam logic [7:0]  PP_B       = 8'(PP_INIT);
    localparam logic [7:0]  DMG0_B     = 8'(DMG0);
    localparam logic [7:0]  DMG1_B     = 8'(DMG1);
    localparam logic [7:0]  STRUGGLE_B = 8'(STRUGGLE_DMG);
    localparam logic [15:0] WAIT_B     = 16'(ENEMY_WAIT_FRAMES);

    state_t      state_q, state_d;
    logic [7:0]  player_hp_q, player_hp_d;
    logic [7:0]  enemy_hp_q, enemy_hp_d;
    logic [7:0]  p_pp_q [2];
    logic [7:0]  p_pp_d [2];
    logic [7:0]  e_pp_q [2];
    logic [7:0]  e_pp_d [2];
    logic        sel_q, sel_d;
    logic        struggle_q, struggle_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        move_err_q, move_err_d;
    logic        move_ready_q, move_ready_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;

    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    logic        p_out;
    logic        p_move_ok;
    logic [7:0]  p_dmg;
    logic [7:0]  enemy_hp_hit;
    logic        e_out;
    logic        e_sel;
    logic [7:0]  e_dmg;
    logic [7:0]  player_hp_hit;
    logic        wait_done;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:1];

    // Damage and post-hit HP are precomputed so the next-state logic can see the outcome.
    assign p_out         = (p_pp_q[0] == 8'd0) && (p_pp_q[1] == 8'd0);
    assign p_move_ok     = p_out || (p_pp_q[move_sel] != 8'd0);
    assign p_dmg         = struggle_q ? STRUGGLE_B : (sel_q ? DMG1_B : DMG0_B);
    assign enemy_hp_hit  = sat_sub(enemy_hp_q, p_dmg);

    assign e_out         = (e_pp_q[0] == 8'd0) && (e_pp_q[1] == 8'd0);
    assign e_sel         = (e_pp_q[lfsr_q[0]] != 8'd0) ? lfsr_q[0] : ~lfsr_q[0];
    assign e_dmg         = e_out ? STRUGGLE_B : (e_sel ? DMG1_B : DMG0_B);
    assign player_hp_hit = sat_sub(player_hp_q, e_dmg);

    assign wait_done     = (frame_cnt_q + 16'd1) >= WAIT_B;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            player_hp_q  <= 8'd0;
            enemy_hp_q   <= 8'd0;
            sel_q        <= 1'b0;
            struggle_q   <= 1'b0;
            frame_cnt_q  <= 16'd0;
            move_err_q   <= 1'b0;
            move_ready_q <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                p_pp_q[i] <= 8'd0;
                e_pp_q[i] <= 8'd0;
            end
        end else begin
            state_q      <= state_d;
            player_hp_q  <= player_hp_d;
            enemy_hp_q   <= enemy_hp_d;
            sel_q        <= sel_d;
            struggle_q   <= struggle_d;
            frame_cnt_q  <= frame_cnt_d;
            move_err_q   <= move_err_d;
            move_ready_q <= move_ready_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            for (int i = 0; i < 2; i++) begin
                p_pp_q[i] <= p_pp_d[i];
                e_pp_q[i] <= e_pp_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_PLAYER_TURN;
        end else begin
            case (state_q)
                ST_PLAYER_TURN: begin
                    if (move_valid && p_move_ok) begin
                        state_d = ST_PLAYER_HIT;
                    end
                end
                ST_PLAYER_HIT: begin
                    state_d = (enemy_hp_hit == 8'd0) ? ST_WIN : ST_ENEMY_WAIT;
                end
                ST_ENEMY_WAIT: begin
                    if (frame_tick && wait_done) begin
                        state_d = ST_ENEMY_HIT;
                    end
                end
                ST_ENEMY_HIT: begin
                    state_d = (player_hp_hit == 8'd0) ? ST_LOSE : ST_PLAYER_TURN;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        player_hp_d = player_hp_q;
        enemy_hp_d  = enemy_hp_q;
        p_pp_d      = p_pp_q;
        e_pp_d      = e_pp_q;
        sel_d       = sel_q;
        struggle_d  = struggle_q;
        frame_cnt_d = frame_cnt_q;
        move_err_d  = 1'b0;

        if (start) begin
            player_hp_d = P_HP_B;
            enemy_hp_d  = E_HP_B;
            p_pp_d[0]   = PP_B;
            p_pp_d[1]   = PP_B;
            e_pp_d[0]   = PP_B;
            e_pp_d[1]   = PP_B;
            sel_d       = 1'b0;
            struggle_d  = 1'b0;
            frame_cnt_d = 16'd0;
        end else begin
            case (state_q)
                ST_PLAYER_TURN: begin
                    if (move_valid) begin
                        if (p_move_ok) begin
                            sel_d      = move_sel;
                            struggle_d = p_out;
                        end else begin
                            move_err_d = 1'b1;
                        end
                    end
                end
                ST_PLAYER_HIT: begin
                    enemy_hp_d  = enemy_hp_hit;
                    frame_cnt_d = 16'd0;
                    if (!struggle_q) begin
                        p_pp_d[sel_q] = sat_sub(p_pp_q[sel_q], 8'd1);
                    end
                end
                ST_ENEMY_WAIT: begin
                    if (frame_tick) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
                ST_ENEMY_HIT: begin
                    player_hp_d = player_hp_hit;
                    if (!e_out) begin
                        e_pp_d[e_sel] = sat_sub(e_pp_q[e_sel], 8'd1);
                    end
                end
                default: begin
                    move_err_d = 1'b0;
                end
            endcase
        end

        move_ready_d = (state_d == ST_PLAYER_TURN);
        win_d        = (state_d == ST_WIN);
        lose_d       = (state_d == ST_LOSE);
    end

    assign state      = state_q;
    assign hp_bus     = {player_hp_q, enemy_hp_q};
    assign p_pp0      = p_pp_q[0];
    assign p_pp1      = p_pp_q[1];
    assign e_pp0      = e_pp_q[0];
    assign e_pp1      = e_pp_q[1];
    assign move_ready = move_ready_q;
    assign move_err   = move_err_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_battle_controller.sv
// Directed bench: default instance for turn timing, plus two tuned instances
// that reach PP exhaustion / struggle / lose and a saturating win.
module tb_battle_controller;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       frame_tick = 1'b0;
    logic [2:0] start_v    = 3'b000;
    logic [2:0] mvv_v      = 3'b000;
    logic [2:0] mvs_v      = 3'b000;

    logic        mready_w [3];
    logic        merr_w   [3];
    logic [15:0] hp_w     [3];
    logic [7:0]  pp0_w    [3];
    logic [7:0]  pp1_w    [3];
    logic [7:0]  epp0_w   [3];
    logic [7:0]  epp1_w   [3];
    logic [2:0]  st_w     [3];
    logic        win_w    [3];
    logic        lose_w   [3];

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    battle_controller u_dflt (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .start(start_v[0]), .move_valid(mvv_v[0]), .move_sel(mvs_v[0]),
        .move_ready(mready_w[0]), .move_err(merr_w[0]), .hp_bus(hp_w[0]),
        .p_pp0(pp0_w[0]), .p_pp1(pp1_w[0]), .e_pp0(epp0_w[0]), .e_pp1(epp1_w[0]),
        .state(st_w[0]), .win(win_w[0]), .lose(lose_w[0])
    );

    battle_controller #(
        .PLAYER_HP_INIT(120), .ENEMY_HP_INIT(130), .PP_INIT(3), .ENEMY_WAIT_FRAMES(2)
    ) u_lose (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .start(start_v[1]), .move_valid(mvv_v[1]), .move_sel(mvs_v[1]),
        .move_ready(mready_w[1]), .move_err(merr_w[1]), .hp_bus(hp_w[1]),
        .p_pp0(pp0_w[1]), .p_pp1(pp1_w[1]), .e_pp0(epp0_w[1]), .e_pp1(epp1_w[1]),
        .state(st_w[1]), .win(win_w[1]), .lose(lose_w[1])
    );

    battle_controller #(
        .PLAYER_HP_INIT(200), .ENEMY_HP_INIT(22), .PP_INIT(10), .ENEMY_WAIT_FRAMES(2)
    ) u_win (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .start(start_v[2]), .move_valid(mvv_v[2]), .move_sel(mvs_v[2]),
        .move_ready(mready_w[2]), .move_err(merr_w[2]), .hp_bus(hp_w[2]),
        .p_pp0(pp0_w[2]), .p_pp1(pp1_w[2]), .e_pp0(epp0_w[2]), .e_pp1(epp1_w[2]),
        .state(st_w[2]), .win(win_w[2]), .lose(lose_w[2])
    );

    function automatic logic [31:0] pps(input int d);
        return {pp0_w[d], pp1_w[d], epp0_w[d], epp1_w[d]};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        step();
        start_v[d] = 1'b0;
    endtask

    task automatic pulse_move(input int d, input logic sel);
        mvv_v[d] = 1'b1;
        mvs_v[d] = sel;
        step();
        mvv_v[d] = 1'b0;
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // For the 2-frame instances: move, hit, two ticks, enemy hit, settle.
    task automatic play_round(input int d, input logic sel);
        pulse_move(d, sel);
        step();
        tick_once();
        tick_once();
        step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            vecs++;
            if ({st_w[d], hp_w[d], pps(d), mready_w[d], merr_w[d], win_w[d], lose_w[d]} !== 55'd0) begin
                miss++;
                $display("FAIL reset_state[%0d]: got st=%0d hp=%h pp=%h rdy=%b err=%b w=%b l=%b required all zero",
                         d, st_w[d], hp_w[d], pps(d), mready_w[d], merr_w[d], win_w[d], lose_w[d]);
            end
        end
        rst = 1'b0;
        step();
        vecs++;
        if (st_w[0] !== 3'd0) begin
            miss++;
            $display("FAIL reset_release_idle: got state %0d required 0", st_w[0]);
        end
    endtask

    task automatic test_start();
        pulse_start(0);
        vecs++;
        if ({st_w[0], hp_w[0], pps(0), mready_w[0]} !== {3'd1, 16'h6464, 32'h0A0A0A0A, 1'b1}) begin
            miss++;
            $display("FAIL start_load: got st=%0d hp=%h pp=%h rdy=%b required st=1 hp=6464 pp=0a0a0a0a rdy=1",
                     st_w[0], hp_w[0], pps(0), mready_w[0]);
        end
    endtask

    task automatic test_player_hit();
        pulse_move(0, 1'b1);
        vecs++;
        if ({st_w[0], mready_w[0]} !== {3'd2, 1'b0}) begin
            miss++;
            $display("FAIL player_hit_state: got st=%0d rdy=%b required st=2 rdy=0", st_w[0], mready_w[0]);
        end
        step();
        vecs++;
        if ({st_w[0], hp_w[0], pps(0)} !== {3'd3, 16'h644B, 32'h0A090A0A}) begin
            miss++;
            $display("FAIL player_hit_result: got st=%0d hp=%h pp=%h required st=3 hp=644b pp=0a090a0a",
                     st_w[0], hp_w[0], pps(0));
        end
        pulse_move(0, 1'b0);
        vecs++;
        if ({st_w[0], merr_w[0]} !== {3'd3, 1'b0}) begin
            miss++;
            $display("FAIL move_ignored_in_wait: got st=%0d err=%b required st=3 err=0", st_w[0], merr_w[0]);
        end
        repeat (59) tick_once();
        vecs++;
        if (st_w[0] !== 3'd3) begin
            miss++;
            $display("FAIL wait_59_ticks: got state %0d required 3", st_w[0]);
        end
        tick_once();
        vecs++;
        if (st_w[0] !== 3'd4) begin
            miss++;
            $display("FAIL wait_60th_tick: got state %0d required 4", st_w[0]);
        end
        step();
        vecs++;
        if (!((hp_w[0] === 16'h584B && epp0_w[0] === 8'd9 && epp1_w[0] === 8'd10) ||
              (hp_w[0] === 16'h4B4B && epp0_w[0] === 8'd10 && epp1_w[0] === 8'd9)) || st_w[0] !== 3'd1) begin
            miss++;
            $display("FAIL enemy_hit_result: got st=%0d hp=%h epp=%0d/%0d required st=1 and hp=584b epp 9/10 or hp=4b4b epp 10/9",
                     st_w[0], hp_w[0], epp0_w[0], epp1_w[0]);
        end
    endtask

    task automatic test_start_in_wait();
        pulse_move(0, 1'b0);
        step();
        repeat (5) tick_once();
        start_v[0] = 1'b1;
        frame_tick = 1'b1;
        step();
        start_v[0] = 1'b0;
        frame_tick = 1'b0;
        vecs++;
        if ({st_w[0], hp_w[0], pps(0), mready_w[0]} !== {3'd1, 16'h6464, 32'h0A0A0A0A, 1'b1}) begin
            miss++;
            $display("FAIL start_in_wait: got st=%0d hp=%h pp=%h rdy=%b required st=1 hp=6464 pp=0a0a0a0a rdy=1",
                     st_w[0], hp_w[0], pps(0), mready_w[0]);
        end
        pulse_move(0, 1'b1);
        step();
        repeat (59) tick_once();
        vecs++;
        if (st_w[0] !== 3'd3) begin
            miss++;
            $display("FAIL cleared_counter_59: got state %0d required 3", st_w[0]);
        end
        tick_once();
        vecs++;
        if (st_w[0] !== 3'd4) begin
            miss++;
            $display("FAIL cleared_counter_60: got state %0d required 4", st_w[0]);
        end
        step();
        vecs++;
        if (st_w[0] !== 3'd1 || !(hp_w[0][15:8] === 8'd88 || hp_w[0][15:8] === 8'd75)) begin
            miss++;
            $display("FAIL restart_enemy_hit: got st=%0d player_hp=%0d required st=1 player_hp 88 or 75",
                     st_w[0], hp_w[0][15:8]);
        end
    endtask

    task automatic test_move_err_and_lose();
        int exp_php;
        pulse_start(1);
        vecs++;
        if ({st_w[1], hp_w[1], pps(1)} !== {3'd1, 16'h7882, 32'h03030303}) begin
            miss++;
            $display("FAIL lose_cfg_start: got st=%0d hp=%h pp=%h required st=1 hp=7882 pp=03030303",
                     st_w[1], hp_w[1], pps(1));
        end
        repeat (3) play_round(1, 1'b0);
        exp_php = 120 - 12 * (3 - int'(epp0_w[1])) - 25 * (3 - int'(epp1_w[1]));
        vecs++;
        if ({pp0_w[1], pp1_w[1], hp_w[1][7:0]} !== {8'd0, 8'd3, 8'd94} ||
            int'(epp0_w[1]) + int'(epp1_w[1]) != 3 || int'(hp_w[1][15:8]) != exp_php) begin
            miss++;
            $display("FAIL three_w0_rounds: got pp=%h hp=%h required p_pp=00/03 enemy=94 epp sum 3 player=%0d",
                     pps(1), hp_w[1], exp_php);
        end
        pulse_move(1, 1'b0);
        vecs++;
        if ({merr_w[1], st_w[1]} !== {1'b1, 3'd1}) begin
            miss++;
            $display("FAIL move_err_pulse: got err=%b st=%0d required err=1 st=1", merr_w[1], st_w[1]);
        end
        step();
        vecs++;
        if ({merr_w[1], st_w[1], hp_w[1][7:0], pp0_w[1], pp1_w[1]} !== {1'b0, 3'd1, 8'd94, 8'd0, 8'd3} ||
            int'(hp_w[1][15:8]) != exp_php) begin
            miss++;
            $display("FAIL move_err_one_cycle: got err=%b st=%0d hp=%h pp=%h required err=0 st=1 unchanged hp/pp",
                     merr_w[1], st_w[1], hp_w[1], pps(1));
        end
        repeat (3) play_round(1, 1'b1);
        vecs++;
        if ({st_w[1], hp_w[1], pps(1)} !== {3'd1, 16'h0913, 32'h0}) begin
            miss++;
            $display("FAIL pp_exhausted: got st=%0d hp=%h pp=%h required st=1 hp=0913 pp=0",
                     st_w[1], hp_w[1], pps(1));
        end
        play_round(1, 1'b1);
        vecs++;
        if ({st_w[1], hp_w[1], pps(1)} !== {3'd1, 16'h040E, 32'h0}) begin
            miss++;
            $display("FAIL struggle_round: got st=%0d hp=%h pp=%h required st=1 hp=040e pp=0",
                     st_w[1], hp_w[1], pps(1));
        end
        play_round(1, 1'b0);
        vecs++;
        if ({st_w[1], hp_w[1], lose_w[1], win_w[1], mready_w[1]} !== {3'd6, 16'h0009, 1'b1, 1'b0, 1'b0}) begin
            miss++;
            $display("FAIL lose_by_struggle: got st=%0d hp=%h lose=%b win=%b rdy=%b required st=6 hp=0009 lose=1 win=0 rdy=0",
                     st_w[1], hp_w[1], lose_w[1], win_w[1], mready_w[1]);
        end
        pulse_move(1, 1'b1);
        step();
        vecs++;
        if ({st_w[1], hp_w[1], merr_w[1], lose_w[1]} !== {3'd6, 16'h0009, 1'b0, 1'b1}) begin
            miss++;
            $display("FAIL lose_holds: got st=%0d hp=%h err=%b lose=%b required st=6 hp=0009 err=0 lose=1",
                     st_w[1], hp_w[1], merr_w[1], lose_w[1]);
        end
    endtask

    task automatic test_win_saturate();
        pulse_start(2);
        play_round(2, 1'b0);
        vecs++;
        if (hp_w[2][7:0] !== 8'd10 || pp0_w[2] !== 8'd9 || st_w[2] !== 3'd1 ||
            !(hp_w[2][15:8] === 8'd188 || hp_w[2][15:8] === 8'd175)) begin
            miss++;
            $display("FAIL win_setup: got st=%0d hp=%h pp0=%0d required st=1 enemy=10 pp0=9 player 188 or 175",
                     st_w[2], hp_w[2], pp0_w[2]);
        end
        pulse_move(2, 1'b0);
        step();
        vecs++;
        if ({st_w[2], hp_w[2][7:0], pp0_w[2], win_w[2], lose_w[2], mready_w[2]} !==
            {3'd5, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0}) begin
            miss++;
            $display("FAIL win_saturate: got st=%0d enemy=%0d pp0=%0d win=%b lose=%b rdy=%b required st=5 enemy=0 pp0=8 win=1 lose=0 rdy=0",
                     st_w[2], hp_w[2][7:0], pp0_w[2], win_w[2], lose_w[2], mready_w[2]);
        end
        pulse_move(2, 1'b1);
        vecs++;
        if ({st_w[2], merr_w[2], hp_w[2][7:0], pp1_w[2]} !== {3'd5, 1'b0, 8'd0, 8'd10}) begin
            miss++;
            $display("FAIL win_ignores_move: got st=%0d err=%b enemy=%0d pp1=%0d required st=5 err=0 enemy=0 pp1=10",
                     st_w[2], merr_w[2], hp_w[2][7:0], pp1_w[2]);
        end
        pulse_start(2);
        vecs++;
        if ({st_w[2], hp_w[2], pps(2), win_w[2]} !== {3'd1, 16'hC816, 32'h0A0A0A0A, 1'b0}) begin
            miss++;
            $display("FAIL win_restart: got st=%0d hp=%h pp=%h win=%b required st=1 hp=c816 pp=0a0a0a0a win=0",
                     st_w[2], hp_w[2], pps(2), win_w[2]);
        end
    endtask

    task automatic test_mid_reset();
        pulse_move(0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        vecs++;
        if ({st_w[0], hp_w[0]} !== {3'd0, 16'h0000}) begin
            miss++;
            $display("FAIL async_reset: got st=%0d hp=%h required st=0 hp=0000", st_w[0], hp_w[0]);
        end
        step();
        rst = 1'b0;
        step();
        pulse_move(0, 1'b1);
        step();
        vecs++;
        if ({st_w[0], hp_w[0], pps(0), mready_w[0], merr_w[0]} !== {3'd0, 16'h0, 32'h0, 1'b0, 1'b0}) begin
            miss++;
            $display("FAIL idle_after_reset: got st=%0d hp=%h pp=%h rdy=%b err=%b required all zero",
                     st_w[0], hp_w[0], pps(0), mready_w[0], merr_w[0]);
        end
        pulse_start(0);
        vecs++;
        if ({st_w[0], hp_w[0], mready_w[0]} !== {3'd1, 16'h6464, 1'b1}) begin
            miss++;
            $display("FAIL restart_after_reset: got st=%0d hp=%h rdy=%b required st=1 hp=6464 rdy=1",
                     st_w[0], hp_w[0], mready_w[0]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vecs);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start();
        test_player_hit();
        test_start_in_wait();
        test_move_err_and_lose();
        test_win_saturate();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
